// File: rtl/block_sum_controller_if.sv
// RAM-side bus between the block-sum controller (master) and its single-port RAM (slave).
interface block_sum_controller_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] acc_data_in;
   logic              mem_read_enable;
   logic [ADDR_W-1:0] mem_address;
   logic              mem_write_enable;
   logic [DATA_W-1:0] acc_data_out;

   modport master (
      input  acc_data_in,
      output mem_read_enable,
      output mem_address,
      output mem_write_enable,
      output acc_data_out
   );

   modport slave (
      output acc_data_in,
      input  mem_read_enable,
      input  mem_address,
      input  mem_write_enable,
      input  acc_data_out
   );
endinterface

// File: rtl/block_sum_controller.sv
// Walks the RAM in blocks, sums the first BLOCK_SIZE-1 words of each block into its last word,
// repeats for NUM_PASSES passes with a ready pulse per pass, then idles until reset.
module block_sum_controller #(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 16,
   parameter int BLOCK_SIZE = 8,
   parameter int NUM_PASSES = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   block_sum_controller_if.master  mem,
   output logic                    ready
);
   localparam int WORD_W = $clog2(BLOCK_SIZE);
   localparam int BLK_W  = ADDR_W - WORD_W;
   localparam int PASS_W = $clog2(NUM_PASSES + 1);

   localparam logic [WORD_W-1:0] LAST_RD_WORD = WORD_W'(BLOCK_SIZE - 2);
   localparam logic [WORD_W-1:0] SUM_WORD     = WORD_W'(BLOCK_SIZE - 1);
   localparam logic [BLK_W-1:0]  LAST_BLOCK   = {BLK_W{1'b1}};
   localparam logic [PASS_W-1:0] PASS_LIMIT   = PASS_W'(NUM_PASSES);

   typedef enum logic [2:0] {
      S_READ  = 3'd0,
      S_ACC   = 3'd1,
      S_WRITE = 3'd2,
      S_CLEAR = 3'd3,
      S_READY = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [BLK_W-1:0]    block_q, block_d;
   logic [PASS_W-1:0]   pass_q, pass_d;
   logic [DATA_W-1:0]   acc_q, acc_d;
   logic                pend_q, pend_d;
   logic                rden_q, rden_d;
   logic                wren_q, wren_d;
   logic                ready_q, ready_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   dout_q;

   // Next-state and next-output logic; outputs are registered, so RAM data from a read
   // strobe arrives one cycle later and is folded in via the pending flag.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      block_d = block_q;
      pass_d  = pass_q;
      pend_d  = 1'b0;
      acc_d   = pend_q ? (acc_q + mem.acc_data_in) : acc_q;
      rden_d  = 1'b0;
      wren_d  = 1'b0;
      ready_d = 1'b0;
      addr_d  = addr_q;
      case (state_q)
         S_READ: begin
            rden_d  = 1'b1;
            addr_d  = {block_q, word_q};
            state_d = S_ACC;
         end
         S_ACC: begin
            pend_d = 1'b1;
            if (word_q == LAST_RD_WORD) begin
               state_d = S_WRITE;
            end else begin
               word_d  = word_q + WORD_W'(1);
               state_d = S_READ;
            end
         end
         S_WRITE: begin
            wren_d  = 1'b1;
            addr_d  = {block_q, SUM_WORD};
            state_d = S_CLEAR;
         end
         S_CLEAR: begin
            acc_d  = {DATA_W{1'b0}};
            word_d = {WORD_W{1'b0}};
            if (block_q != LAST_BLOCK) begin
               block_d = block_q + BLK_W'(1);
               state_d = S_READ;
            end else begin
               block_d = {BLK_W{1'b0}};
               pass_d  = pass_q + PASS_W'(1);
               state_d = S_READY;
            end
         end
         S_READY: begin
            ready_d = 1'b1;
            if (pass_q == PASS_LIMIT) begin
               state_d = S_DONE;
            end else begin
               state_d = S_READ;
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_READ;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_READ;
         word_q  <= {WORD_W{1'b0}};
         block_q <= {BLK_W{1'b0}};
         pass_q  <= {PASS_W{1'b0}};
         acc_q   <= {DATA_W{1'b0}};
         pend_q  <= 1'b0;
         rden_q  <= 1'b0;
         wren_q  <= 1'b0;
         ready_q <= 1'b0;
         addr_q  <= {ADDR_W{1'b0}};
         dout_q  <= {DATA_W{1'b0}};
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         block_q <= block_d;
         pass_q  <= pass_d;
         acc_q   <= acc_d;
         pend_q  <= pend_d;
         rden_q  <= rden_d;
         wren_q  <= wren_d;
         ready_q <= ready_d;
         addr_q  <= addr_d;
         dout_q  <= acc_d;
      end
   end

   assign mem.mem_read_enable  = rden_q;
   assign mem.mem_write_enable = wren_q;
   assign mem.mem_address      = addr_q;
   assign mem.acc_data_out     = dout_q;
   assign ready                = ready_q;
endmodule

// File: tb/tb_block_sum_controller.sv
// Directed bench: drives the controller against a behavioural 32x16 RAM and checks
// strobe sequences, written sums, ready timing, reset restart and 16-bit wrap.
module tb_block_sum_controller;
   typedef struct {
      logic [4:0]  addr;
      logic [15:0] data;
   } wr_vec_t;

   logic clock;
   logic reset;
   logic ready;
   logic [1:0] ram_cmd;
   logic [15:0] ram [32];

   int ncmp;
   int nfail;
   int cyc;
   int first_rd_cyc;
   int both_cnt;
   int b2b_cnt;
   int idle_act;
   logic prev_rden;
   logic [4:0] rd_q[$];
   wr_vec_t    wr_q[$];
   int         rdy_q[$];
   wr_vec_t    wr_tab[8];

   block_sum_controller_if bus ();

   block_sum_controller dut (
      .clock (clock),
      .reset (reset),
      .mem   (bus),
      .ready (ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural RAM: load commands, write, then registered read port.
   always @(posedge clock) begin
      if (ram_cmd == 2'd1) begin
         for (int i = 0; i < 32; i++) ram[i] <= 16'(i);
      end else if (ram_cmd == 2'd2) begin
         for (int i = 0; i < 7; i++) ram[i] <= 16'hFFFF;
      end else if (bus.mem_write_enable) begin
         ram[bus.mem_address] <= bus.acc_data_out;
      end
      if (bus.mem_read_enable) bus.acc_data_in <= ram[bus.mem_address];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic clear_mon();
      cyc = 0;
      first_rd_cyc = -1;
      both_cnt = 0;
      b2b_cnt = 0;
      idle_act = 0;
      prev_rden = 1'b0;
      rd_q.delete();
      wr_q.delete();
      rdy_q.delete();
   endtask

   task automatic do_reset(input logic [1:0] cmd);
      @(negedge clock);
      reset = 1'b1;
      ram_cmd = cmd;
      @(negedge clock);
      @(negedge clock);
      chk("outputs_in_reset",
          {11'd0, ready, bus.mem_read_enable, bus.mem_write_enable, bus.mem_address, bus.acc_data_out},
          32'd0);
      reset = 1'b0;
      ram_cmd = 2'd0;
      clear_mon();
   endtask

   task automatic run(input int n);
      wr_vec_t w;
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         cyc++;
         if (rdy_q.size() >= 2 && (ready || bus.mem_read_enable || bus.mem_write_enable)) idle_act++;
         if (bus.mem_read_enable) begin
            if (prev_rden) b2b_cnt++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            rd_q.push_back(bus.mem_address);
         end
         if (bus.mem_write_enable) begin
            w.addr = bus.mem_address;
            w.data = bus.acc_data_out;
            wr_q.push_back(w);
         end
         if (bus.mem_read_enable && bus.mem_write_enable) both_cnt++;
         if (ready) rdy_q.push_back(cyc);
         prev_rden = bus.mem_read_enable;
      end
   endtask

   task automatic check_full_run();
      chk("first_read_cycle", 32'(first_rd_cyc), 32'd1);
      chk("read_count", 32'(rd_q.size()), 32'd56);
      for (int i = 0; i < rd_q.size() && i < 56; i++)
         chk("read_addr", 32'(rd_q[i]), 32'(8 * ((i % 28) / 7) + (i % 7)));
      chk("write_count", 32'(wr_q.size()), 32'd8);
      for (int i = 0; i < wr_q.size() && i < 8; i++) begin
         chk("write_addr", 32'(wr_q[i].addr), 32'(wr_tab[i].addr));
         chk("write_data", 32'(wr_q[i].data), 32'(wr_tab[i].data));
      end
      chk("ready_count", 32'(rdy_q.size()), 32'd2);
      if (rdy_q.size() >= 1) chk("ready1_cycle", 32'(rdy_q[0]), 32'd65);
      if (rdy_q.size() >= 2) chk("ready2_cycle", 32'(rdy_q[1]), 32'd130);
      chk("rd_wr_overlap", 32'(both_cnt), 32'd0);
      chk("read_back_to_back", 32'(b2b_cnt), 32'd0);
      chk("activity_in_done", 32'(idle_act), 32'd0);
   endtask

   initial begin
      ncmp = 0;
      nfail = 0;
      reset = 1'b1;
      ram_cmd = 2'd1;
      clear_mon();
      for (int i = 0; i < 8; i++) begin
         wr_tab[i].addr = 5'(8 * (i % 4) + 7);
         wr_tab[i].data = 16'(56 * (i % 4) + 21);
      end
      chk("tab_sum0", 32'(wr_tab[0].data), 32'd21);

      // Clean run from power-up contents, two passes then idle.
      do_reset(2'd1);
      run(340);
      check_full_run();

      // Reset in block 2 of the first pass, then a full restart.
      do_reset(2'd1);
      run(40);
      chk("pre_abort_writes", 32'(wr_q.size()), 32'd2);
      do_reset(2'd0);
      run(340);
      check_full_run();

      // Words 0..6 = 0xFFFF: sum wraps to 0xFFF9.
      do_reset(2'd2);
      run(20);
      chk("wrap_write_count", 32'(wr_q.size()), 32'd1);
      if (wr_q.size() >= 1) begin
         chk("wrap_write_addr", 32'(wr_q[0].addr), 32'd7);
         chk("wrap_write_data", 32'(wr_q[0].data), 32'h0000FFF9);
      end
      chk("wrap_ram_word7", 32'(ram[7]), 32'h0000FFF9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
